// File: rtl/pifo_task_queue.sv
// pifo_task_queue: multi-port task FIFOs with round-robin issue to the PIFO core.
// Optional: define PIFO_TQ_STATS_EN for per-port accepted/dropped counters.
module pifo_task_queue #(
  parameter int NPORT = 4,
  parameter int PTW   = 8,
  parameter int TIW   = 2,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(NPORT)
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  input  logic [NPORT-1:0]       i_push,
  input  logic [NPORT-1:0]       i_pop,
  input  logic [NPORT*PTW-1:0]   i_push_data,
  input  logic [NPORT*TIW-1:0]   i_tree_id,
  output logic [NPORT-1:0]       o_task_fifo_full,
  output logic [NPORT-1:0]       o_task_fifo_ovf,
  output logic                   o_core_valid,
  output logic                   o_core_push,
  output logic                   o_core_pop,
  output logic [PTW-1:0]         o_core_data,
  output logic [TIW-1:0]         o_core_tree_id,
  output logic [PW-1:0]          o_core_port,
  input  logic                   i_core_ready,
  input  logic                   i_core_pop_valid,
  input  logic [PW-1:0]          i_core_pop_port,
  input  logic [PTW-1:0]         i_core_pop_data,
  output logic [NPORT-1:0]       o_pop_valid,
  output logic [NPORT*PTW-1:0]   o_pop_data
`ifdef PIFO_TQ_STATS_EN
  ,
  output logic [NPORT*16-1:0]    o_stat_acc,
  output logic [NPORT*16-1:0]    o_stat_drop
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic           push;
    logic           pop;
    logic [TIW-1:0] tid;
    logic [PTW-1:0] data;
  } ent_t;

  ent_t           mem_q [NPORT][DEPTH];
  ent_t           mem_d [NPORT][DEPTH];
  logic [CW-1:0]  cnt_q [NPORT];
  logic [CW-1:0]  cnt_d [NPORT];
  logic [AW-1:0]  wr_q  [NPORT];
  logic [AW-1:0]  wr_d  [NPORT];
  logic [AW-1:0]  rd_q  [NPORT];
  logic [AW-1:0]  rd_d  [NPORT];
  logic [NPORT-1:0] full_q, full_d;
  logic [NPORT-1:0] ovf_q, ovf_d;
  logic [NPORT-1:0] req, enq, deq;

  logic [PW-1:0]  rr_q, rr_d;
  logic [PW-1:0]  gnt;
  logic           found;
  logic           load;
  int             arb_idx;

  ent_t           out_q, out_d;
  logic           vld_q, vld_d;
  logic [PW-1:0]  port_q, port_d;

  logic [NPORT-1:0]     pv_q, pv_d;
  logic [NPORT*PTW-1:0] pd_q, pd_d;

  // first non-empty port at or after rr_q, wrapping
  always_comb begin
    found   = 1'b0;
    gnt     = '0;
    arb_idx = 0;
    for (int i = 0; i < NPORT; i++) begin
      arb_idx = (int'(rr_q) + i) % NPORT;
      if (!found && cnt_q[arb_idx] != '0) begin
        found = 1'b1;
        gnt   = PW'(arb_idx);
      end
    end
  end

  always_comb begin
    load   = !vld_q || i_core_ready;
    rr_d   = rr_q;
    vld_d  = vld_q;
    out_d  = out_q;
    port_d = port_q;
    deq    = '0;
    if (load) begin
      vld_d = found;
      if (found) begin
        deq[gnt] = 1'b1;
        out_d    = mem_q[gnt][rd_q[gnt]];
        port_d   = gnt;
        rr_d     = (int'(gnt) == NPORT - 1) ? '0 : gnt + 1'b1;
      end
    end
  end

  // full is taken from the registered count, so a slot freed this cycle
  // does not admit a request in the same cycle
  always_comb begin
    mem_d = mem_q;
    ovf_d = ovf_q;
    for (int p = 0; p < NPORT; p++) begin
      req[p] = i_push[p] | i_pop[p];
      enq[p] = req[p] & ~full_q[p];
      wr_d[p] = wr_q[p];
      rd_d[p] = rd_q[p];
      if (req[p] && full_q[p])
        ovf_d[p] = 1'b1;
      if (enq[p]) begin
        mem_d[p][wr_q[p]] = '{
          push: i_push[p],
          pop:  i_pop[p],
          tid:  i_tree_id[p*TIW +: TIW],
          data: i_push[p] ? i_push_data[p*PTW +: PTW] : '0
        };
        wr_d[p] = wr_q[p] + 1'b1;
      end
      if (deq[p])
        rd_d[p] = rd_q[p] + 1'b1;
      cnt_d[p]  = cnt_q[p] + CW'(enq[p]) - CW'(deq[p]);
      full_d[p] = (cnt_d[p] == CW'(DEPTH));
    end
  end

  always_comb begin
    pv_d = '0;
    pd_d = pd_q;
    if (i_core_pop_valid && int'(i_core_pop_port) < NPORT) begin
      pv_d[i_core_pop_port] = 1'b1;
      pd_d[int'(i_core_pop_port)*PTW +: PTW] = i_core_pop_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int p = 0; p < NPORT; p++) begin
        for (int e = 0; e < DEPTH; e++)
          mem_q[p][e] <= '0;
        cnt_q[p] <= '0;
        wr_q[p]  <= '0;
        rd_q[p]  <= '0;
      end
      full_q <= '0;
      ovf_q  <= '0;
      rr_q   <= '0;
      out_q  <= '0;
      vld_q  <= 1'b0;
      port_q <= '0;
      pv_q   <= '0;
      pd_q   <= '0;
    end else begin
      mem_q  <= mem_d;
      cnt_q  <= cnt_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
      rr_q   <= rr_d;
      out_q  <= out_d;
      vld_q  <= vld_d;
      port_q <= port_d;
      pv_q   <= pv_d;
      pd_q   <= pd_d;
    end
  end

  assign o_task_fifo_full = full_q;
  assign o_task_fifo_ovf  = ovf_q;
  assign o_core_valid     = vld_q;
  assign o_core_push      = out_q.push;
  assign o_core_pop       = out_q.pop;
  assign o_core_data      = out_q.data;
  assign o_core_tree_id   = out_q.tid;
  assign o_core_port      = port_q;
  assign o_pop_valid      = pv_q;
  assign o_pop_data       = pd_q;

`ifdef PIFO_TQ_STATS_EN
  logic [15:0] acc_q [NPORT];
  logic [15:0] acc_d [NPORT];
  logic [15:0] drp_q [NPORT];
  logic [15:0] drp_d [NPORT];

  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      acc_d[p] = acc_q[p];
      drp_d[p] = drp_q[p];
      if (enq[p] && acc_q[p] != 16'hFFFF)
        acc_d[p] = acc_q[p] + 16'd1;
      if (req[p] && full_q[p] && drp_q[p] != 16'hFFFF)
        drp_d[p] = drp_q[p] + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int p = 0; p < NPORT; p++) begin
        acc_q[p] <= '0;
        drp_q[p] <= '0;
      end
    end else begin
      acc_q <= acc_d;
      drp_q <= drp_d;
    end
  end

  always_comb begin
    o_stat_acc  = '0;
    o_stat_drop = '0;
    for (int p = 0; p < NPORT; p++) begin
      o_stat_acc[p*16 +: 16]  = acc_q[p];
      o_stat_drop[p*16 +: 16] = drp_q[p];
    end
  end
`endif

endmodule

// File: tb/tb_pifo_task_queue.sv
// tb_pifo_task_queue: directed table, corner sequences and a queue-model
// random run for pifo_task_queue.
module tb_pifo_task_queue;

  localparam int NP  = 4;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  push, pop;
  logic [31:0] pdata_in;
  logic [7:0]  tid_in;
  logic        ready;
  logic        cpv;
  logic [1:0]  cpport;
  logic [7:0]  cpdata;
  logic [3:0]  full, ovf;
  logic        cvalid, cpush, cpop;
  logic [7:0]  cdata;
  logic [1:0]  ctid, cport;
  logic [3:0]  pvalid;
  logic [31:0] podata;

  logic        b_pv;
  logic [1:0]  b_pport;
  logic [7:0]  b_pdata;
  logic [2:0]  b_full, b_ovf;
  logic        b_cvalid, b_cpush, b_cpop;
  logic [7:0]  b_cdata;
  logic [1:0]  b_ctid, b_cport;
  logic [2:0]  b_pvalid;
  logic [23:0] b_podata;

`ifdef PIFO_TQ_STATS_EN
  logic [63:0] st_acc, st_drop;
  logic [47:0] b_acc, b_drop;
`endif

  always #5 clk = ~clk;

  pifo_task_queue u_dut (
    .i_clk(clk), .i_arst_n(rst_n),
    .i_push(push), .i_pop(pop),
    .i_push_data(pdata_in), .i_tree_id(tid_in),
    .o_task_fifo_full(full), .o_task_fifo_ovf(ovf),
    .o_core_valid(cvalid), .o_core_push(cpush), .o_core_pop(cpop),
    .o_core_data(cdata), .o_core_tree_id(ctid), .o_core_port(cport),
    .i_core_ready(ready),
    .i_core_pop_valid(cpv), .i_core_pop_port(cpport),
    .i_core_pop_data(cpdata),
    .o_pop_valid(pvalid), .o_pop_data(podata)
`ifdef PIFO_TQ_STATS_EN
    , .o_stat_acc(st_acc), .o_stat_drop(st_drop)
`endif
  );

  pifo_task_queue #(.NPORT(3)) u_dut3 (
    .i_clk(clk), .i_arst_n(rst_n),
    .i_push(3'b0), .i_pop(3'b0),
    .i_push_data(24'h0), .i_tree_id(6'h0),
    .o_task_fifo_full(b_full), .o_task_fifo_ovf(b_ovf),
    .o_core_valid(b_cvalid), .o_core_push(b_cpush), .o_core_pop(b_cpop),
    .o_core_data(b_cdata), .o_core_tree_id(b_ctid), .o_core_port(b_cport),
    .i_core_ready(1'b1),
    .i_core_pop_valid(b_pv), .i_core_pop_port(b_pport),
    .i_core_pop_data(b_pdata),
    .o_pop_valid(b_pvalid), .o_pop_data(b_podata)
`ifdef PIFO_TQ_STATS_EN
    , .o_stat_acc(b_acc), .o_stat_drop(b_drop)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model: plain per-port queues plus one output slot
  typedef struct {
    bit       push;
    bit       pop;
    bit [7:0] data;
    bit [1:0] tid;
  } ment_t;

  ment_t     mq [NP][$];
  ment_t     m_out;
  bit        m_valid;
  int        m_port;
  int        m_rr;
  bit [3:0]  m_ovf;
  bit [3:0]  m_pv;
  bit [31:0] m_pd;

  task automatic model_reset();
    for (int p = 0; p < NP; p++) mq[p].delete();
    m_valid = 0; m_port = 0; m_rr = 0;
    m_ovf = '0; m_pv = '0; m_pd = '0;
    m_out = '{0, 0, 8'd0, 2'd0};
  endtask

  task automatic model_step();
    int sz [NP];
    int g;
    ment_t e;
    for (int p = 0; p < NP; p++) sz[p] = mq[p].size();
    m_pv = '0;
    if (cpv) begin
      m_pv[cpport] = 1'b1;
      m_pd[int'(cpport)*8 +: 8] = cpdata;
    end
    if (!m_valid || ready) begin
      m_valid = 0;
      for (int i = 0; i < NP; i++) begin
        g = (m_rr + i) % NP;
        if (!m_valid && sz[g] > 0) begin
          m_out = mq[g].pop_front();
          m_port = g;
          m_valid = 1;
          m_rr = (g + 1) % NP;
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (push[p] || pop[p]) begin
        if (sz[p] == DEP) m_ovf[p] = 1'b1;
        else begin
          e.push = push[p];
          e.pop  = pop[p];
          e.data = pdata_in[p*8 +: 8];
          e.tid  = tid_in[p*2 +: 2];
          mq[p].push_back(e);
        end
      end
    end
  endtask

  task automatic check_model();
    bit [3:0] ef;
    for (int p = 0; p < NP; p++) ef[p] = (mq[p].size() == DEP);
    chk("m_valid", cvalid, m_valid);
    if (m_valid) begin
      chk("m_push", cpush, m_out.push);
      chk("m_pop", cpop, m_out.pop);
      chk("m_port", cport, m_port);
      if (m_out.push) begin
        chk("m_data", cdata, m_out.data);
        chk("m_tid", ctid, m_out.tid);
      end
    end
    chk("m_full", full, ef);
    chk("m_ovf", ovf, m_ovf);
    chk("m_pop_valid", pvalid, m_pv);
    chk("m_pop_data", podata, m_pd);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic set_idle();
    push = '0; pop = '0; cpv = 1'b0; ready = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, cvalid, 0);
    chk({tag, "_push"}, cpush, 0);
    chk({tag, "_pop"}, cpop, 0);
    chk({tag, "_data"}, cdata, 0);
    chk({tag, "_tid"}, ctid, 0);
    chk({tag, "_port"}, cport, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_pv"}, pvalid, 0);
    chk({tag, "_pd"}, podata, 0);
`ifdef PIFO_TQ_STATS_EN
    chk({tag, "_stat_acc"}, st_acc, 0);
    chk({tag, "_stat_drop"}, st_drop, 0);
`endif
  endtask

  task automatic drain();
    int n;
    bit busy;
    n = 0;
    set_idle();
    busy = 1;
    while (busy && n < 64) begin
      cycle();
      n++;
      busy = m_valid;
      for (int p = 0; p < NP; p++) if (mq[p].size() != 0) busy = 1;
    end
    chk("drain_bound", busy, 0);
  endtask

  typedef struct {
    bit [3:0] push;
    bit [3:0] pop;
    bit [7:0] d;
    bit [1:0] t;
    bit       rdy;
    bit       pv;
    bit [1:0] pp;
    bit [7:0] pdd;
    bit       ev;
    bit [7:0] ed;
    bit [1:0] et;
    bit [1:0] eport;
    bit [3:0] epv;
    bit [7:0] epd3;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int got[$];
    int gq[$];
    int pc [NP];
    tbl[0] = '{4'b0100, 4'b0, 8'd1, 2'd2, 1, 0, 2'd0, 8'h00,
               0, 8'd0, 2'd0, 2'd0, 4'b0000, 8'h00};
    tbl[1] = '{4'b0100, 4'b0, 8'd2, 2'd2, 1, 0, 2'd0, 8'h00,
               1, 8'd1, 2'd2, 2'd2, 4'b0000, 8'h00};
    tbl[2] = '{4'b0100, 4'b0, 8'd3, 2'd2, 1, 0, 2'd0, 8'h00,
               1, 8'd2, 2'd2, 2'd2, 4'b0000, 8'h00};
    tbl[3] = '{4'b0000, 4'b0, 8'd0, 2'd0, 1, 0, 2'd0, 8'h00,
               1, 8'd3, 2'd2, 2'd2, 4'b0000, 8'h00};
    tbl[4] = '{4'b0000, 4'b0, 8'd0, 2'd0, 1, 1, 2'd3, 8'h2A,
               0, 8'd0, 2'd0, 2'd0, 4'b1000, 8'h2A};
    tbl[5] = '{4'b0000, 4'b0, 8'd0, 2'd0, 1, 0, 2'd0, 8'h00,
               0, 8'd0, 2'd0, 2'd0, 4'b0000, 8'h2A};

    rst_n = 1'b0;
    push = '0; pop = '0; pdata_in = '0; tid_in = '0;
    ready = 1'b1; cpv = 1'b0; cpport = '0; cpdata = '0;
    b_pv = 1'b0; b_pport = '0; b_pdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_zero("reset");

    for (int i = 0; i < 6; i++) begin
      push = tbl[i].push;
      pop = tbl[i].pop;
      pdata_in = {4{tbl[i].d}};
      tid_in = {4{tbl[i].t}};
      ready = tbl[i].rdy;
      cpv = tbl[i].pv;
      cpport = tbl[i].pp;
      cpdata = tbl[i].pdd;
      cycle();
      chk("tbl_valid", cvalid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk("tbl_data", cdata, tbl[i].ed);
        chk("tbl_tid", ctid, tbl[i].et);
        chk("tbl_port", cport, tbl[i].eport);
        chk("tbl_push", cpush, 1);
        chk("tbl_pop", cpop, 0);
      end
      chk("tbl_pv", pvalid, tbl[i].epv);
      chk("tbl_pd3", podata[31:24], tbl[i].epd3);
    end

    // out-of-range return tag on a 3-port instance
    set_idle();
    b_pv = 1'b1; b_pport = 2'd3; b_pdata = 8'h11;
    cycle();
    chk("tag_oob_pv", b_pvalid, 3'b000);
    chk("tag_oob_pd", b_podata, 24'h0);
    b_pport = 2'd2; b_pdata = 8'h55;
    cycle();
    chk("tag2_pv", b_pvalid, 3'b100);
    chk("tag2_pd", b_podata[23:16], 8'h55);
    b_pv = 1'b0;
    cycle();
    chk("tag2_clear", b_pvalid, 3'b000);

    // overflow with stalled core
    drain();
    ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      push = 4'b0001;
      pdata_in = {24'h0, 8'(k)};
      cycle();
    end
    chk("ovf_full5", full[0], 1);
    chk("ovf_flag5", ovf[0], 0);
    pdata_in = {24'h0, 8'd6};
    cycle();
    chk("ovf_flag6", ovf[0], 1);
    push = '0;
    got.delete();
    if (cvalid) got.push_back(int'(cdata));
    ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      cycle();
      if (!cvalid) break;
      got.push_back(int'(cdata));
    end
    chk("ovf_count", got.size(), 5);
    foreach (got[i]) chk("ovf_order", got[i], i + 1);

    // round robin under full load
    drain();
    gq.delete();
    for (int c = 0; c < 16; c++) begin
      push = (c < 8) ? 4'hF : 4'h0;
      pdata_in = $urandom;
      tid_in = 8'($urandom);
      cycle();
      if (cvalid) gq.push_back(int'(cport));
    end
    chk("rr_grants", gq.size() >= 12, 1);
    for (int i = 1; i < 12 && i < gq.size(); i++)
      chk("rr_next", gq[i], (gq[i-1] + 1) % NP);
    for (int p = 0; p < NP; p++) pc[p] = 0;
    for (int i = 0; i < 8 && i < gq.size(); i++) pc[gq[i]]++;
    for (int p = 0; p < NP; p++) chk("rr_starve", pc[p] >= 2, 1);

    // combined push+pop entry
    drain();
    push = 4'b0010; pop = 4'b0010;
    pdata_in = {4{8'd7}}; tid_in = {4{2'd1}};
    cycle();
    set_idle();
    cycle();
    chk("pp_valid", cvalid, 1);
    chk("pp_push", cpush, 1);
    chk("pp_pop", cpop, 1);
    chk("pp_data", cdata, 7);
    chk("pp_port", cport, 1);
    cycle();
    chk("pp_single", cvalid, 0);

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      push = 4'($urandom);
      pop = 4'($urandom) & 4'($urandom);
      pdata_in = $urandom;
      tid_in = 8'($urandom);
      ready = ($urandom % 4) != 0;
      cpv = 1'($urandom);
      cpport = 2'($urandom);
      cpdata = 8'($urandom);
      cycle();
    end

    // reset in the middle of a burst
    set_idle();
    ready = 1'b0;
    push = 4'b0111;
    pdata_in = 32'h00332211;
    cycle();
    set_idle();
    ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("post_rst_idle", cvalid, 0);
    end
`ifdef PIFO_TQ_STATS_EN
    chk("stat_acc0", st_acc, 0);
    push = 4'b0001;
    repeat (2) cycle();
    set_idle();
    cycle();
    chk("stat_acc2", st_acc[15:0], 16'd2);
    chk("stat_drop0", st_drop, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
